ntt_butterfly: RTL
==================

# ntt_butterfly

Pipelined radix-2 NTT butterfly; the consumer of `mod_multiplication` in the NTT datapath. Each beat takes two coefficients and a twiddle and returns the butterfly pair mod `Q`. Cooley-Tukey (forward) is always present; Gentleman-Sande (inverse) is a compile option. A free-running valid pipeline matches data alignment to the multiplier's fixed latency.

## Interface
- `K`, default `` `K ``: coefficient width.
- `MUL_LAT`, default 7: latency of `mod_multiplication` in cycles. Must equal the instantiated multiplier's actual latency.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  beat present on `a`, `b`, `w`.
- `a`  in  K  top coefficient, < `Q`.
- `b`  in  K  bottom coefficient, < `Q`.
- `w`  in  K  twiddle, < `Q`.
- `mode`  in  1  0 = CT, 1 = GS. Honoured only under `NTT_BUTTERFLY_INV_EN`.
- `out_valid`  out  1  result beat present.
- `x0`  out  K  first output.
- `x1`  out  K  second output.
- `busy`  out  1  any beat in flight, including the output stage.

## Operation
- CT: `x0 = (a + w·b) mod Q`, `x1 = (a − w·b) mod Q`.
- GS: `x0 = (a + b) mod Q`, `x1 = ((a − b)·w) mod Q`.
- Stage 0 input registers capture `a`, `b`, `w`, `in_valid`, plus the mode tag, every cycle.
- CT path:
  - The multiplier takes stage-0 `b`, `w`.
  - `a` is delayed `MUL_LAT` cycles to align with the product.
  - A registered mod add/sub produces `x0`/`x1`.
- GS path:
  - Registered mod add/sub on stage-0 `a`, `b`.
  - The difference and a 1-cycle-delayed `w` feed the multiplier.
  - The sum is delayed `MUL_LAT` cycles.
  - The product drives `x1` directly from the output register.
- Mod add: `s = a + b` at K+1 bits; subtract `Q` if `s ≥ Q`.
- Mod sub: `d = a − b`; add `Q` if borrow. Results are always < `Q`.
- Inputs ≥ `Q` are illegal; the output is then unspecified, but the valid timing is unaffected.
- No backpressure. Every accepted beat emerges; the consumer must always take it.
- Mode register `mode_q`:
  - Loads `mode` only in a cycle where `busy == 0`.
  - Beats accepted while `busy == 1` use `mode_q` regardless of `mode`.
  - This prevents CT and GS beats colliding on the shared multiplier.
- Data registers are not reset; only the valid chain, `mode_q` and the outputs are.

## Timing
- Latency L = `MUL_LAT + 2`, identical in both modes.
- `out_valid` at cycle t+L exactly mirrors `in_valid` at cycle t.
- Throughput: one beat per cycle; back-to-back beats give back-to-back results.
- `busy` = OR of all valid-chain bits; it deasserts the cycle after the last `out_valid`.
- Reset, including mid-stream:
  - `out_valid`, `busy`, `x0`, `x1` and `mode_q` all go to 0 immediately.
  - In-flight beats are discarded and never appear.
  - The first beat after `rst_n` rises emerges L cycles later.
- Mode change on the first cycle with `busy == 0`: a beat presented that same cycle uses the new `mode`.
- Gaps in `in_valid` reproduce as identical gaps in `out_valid`.

## Configuration
- `NTT_BUTTERFLY_INV_EN` defined:
  - GS path, `mode` input and `mode_q` are present.
- Not defined:
  - CT only; the `mode` port is retained but ignored.
  - `mode_q` is tied to 0 and no GS logic is synthesised.
  - Latency and `busy` behaviour are unchanged.

## Structure
- `ntt_pkg` holds:
  - `mod_add` / `mod_sub` functions.
  - localparam `BFLY_LAT(MUL_LAT)`.
  - The coefficient typedef `coef_t` (`logic [K-1:0]`).
- `Q` and `K` come from the existing parameters header.
- Sub-modules:
  - `mod_addsub`: registered add/sub pair, 1-cycle latency, instantiated once per path.
  - The existing `mod_multiplication`, instantiated once.

## Test plan
- Reset, then single CT beat `a=5, b=3, w=2`: at t+L, `x0=11`, `x1=Q−1`, exactly one `out_valid` pulse.
- CT wrap: `a=Q−1, b=1, w=1` gives `x0=0`, `x1=Q−2`; `a=0, b=1, w=Q−1` gives `x0=Q−1`, `x1=1`.
- Stream of 64 random beats with random `in_valid` gaps: outputs match a golden model; the `out_valid` pattern is the input pattern shifted by L.
- GS (macro on), `a=2, b=5, w=3`: `x0=7`, `x1=(Q−3)·3 mod Q`.
- `mode` toggled while `busy`: in-flight and newly accepted beats use the old mode until drain; the new mode applies from the first `busy==0` cycle.
- `rst_n` pulsed low while 5 beats are in flight: no `out_valid` from those beats; `busy=0` during reset; a post-reset beat emerges at L.

Source files
------------

// File: rtl/ntt_pkg.sv
// ntt_pkg: coefficient type, modular add/sub helpers and latency constants for the NTT datapath
// Defaults for the K/Q macros are supplied here when no parameters header has defined them.
`ifndef K
`define K 12
`endif
`ifndef Q
`define Q 3329
`endif
package ntt_pkg;
    localparam int K           = `K;
    localparam int DEF_MUL_LAT = 7;
    typedef logic [K-1:0] coef_t;
    localparam coef_t Q = coef_t'(`Q);

    function automatic int bfly_lat(input int mul_lat);
        return mul_lat + 2;
    endfunction

    localparam int BFLY_LAT = bfly_lat(DEF_MUL_LAT);

    function automatic coef_t mod_add(input coef_t x, input coef_t y);
        logic [K:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= {1'b0, Q}) ? coef_t'(s - {1'b0, Q}) : s[K-1:0];
    endfunction

    function automatic coef_t mod_sub(input coef_t x, input coef_t y);
        logic [K:0] d;
        d = {1'b0, x} - {1'b0, y};
        return d[K] ? d[K-1:0] + Q : d[K-1:0];
    endfunction
endpackage

// File: rtl/ntt_butterfly_if.sv
// ntt_butterfly_if: beat interface of the NTT butterfly
// master: drives in_valid/a/b/w/mode, sees out_valid/x0/x1/busy; slave: the butterfly itself.
interface ntt_butterfly_if #(
    parameter int K = `K
);
    logic         in_valid;
    logic         mode;
    logic [K-1:0] a;
    logic [K-1:0] b;
    logic [K-1:0] w;
    logic         out_valid;
    logic         busy;
    logic [K-1:0] x0;
    logic [K-1:0] x1;

    modport master(output in_valid, mode, a, b, w, input out_valid, busy, x0, x1);
    modport slave(input in_valid, mode, a, b, w, output out_valid, busy, x0, x1);
endinterface

// File: rtl/mod_addsub.sv
// mod_addsub: registered modular sum/difference pair, 1-cycle latency
// Ports: clk, rst_n (async active-low); a, b operands (< Q); sum_q, diff_q registered results.
module mod_addsub
    import ntt_pkg::*;
#(
    parameter int K = `K
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    output logic [K-1:0] sum_q,
    output logic [K-1:0] diff_q
);
    logic [K-1:0] sum_d, diff_d;

    always_comb begin
        sum_d  = mod_add(a, b);
        diff_d = mod_sub(a, b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            diff_q <= '0;
        end else begin
            sum_q  <= sum_d;
            diff_q <= diff_d;
        end
    end
endmodule

// File: rtl/mod_multiplication.sv
// mod_multiplication: pipelined (a*b) mod Q with a fixed latency of LAT cycles
// Ports: clk; a, b operands (< Q); p product, valid LAT cycles after a/b are presented.
module mod_multiplication
    import ntt_pkg::*;
#(
    parameter int K   = `K,
    parameter int LAT = DEF_MUL_LAT
) (
    input  logic         clk,
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    output logic [K-1:0] p
);
    logic [2*K-1:0]        prod_q, prod_d;
    logic [LAT-2:0][K-1:0] red_q, red_d;

    // one cycle to multiply, one to reduce, the rest is retiming slack
    always_comb begin
        prod_d = {{K{1'b0}}, a} * {{K{1'b0}}, b};
        red_d  = {red_q[LAT-3:0], K'(prod_q % (2*K)'(Q))};
    end

    always_ff @(posedge clk) begin
        prod_q <= prod_d;
        red_q  <= red_d;
    end

    assign p = red_q[LAT-2];
endmodule

// File: rtl/ntt_butterfly.sv
// ntt_butterfly: pipelined radix-2 NTT butterfly, Cooley-Tukey always, Gentleman-Sande optional
// Ports: clk, rst_n (async active-low); bus (ntt_butterfly_if.slave): in_valid/a/b/w/mode in,
//        out_valid/x0/x1/busy out. Latency MUL_LAT+2 in both modes, one beat per cycle.
// Build option: NTT_BUTTERFLY_INV_EN adds the GS path and the mode register.
module ntt_butterfly
    import ntt_pkg::*;
#(
    parameter int K       = `K,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic           clk,
    input  logic           rst_n,
    ntt_butterfly_if.slave bus
);
    localparam int L = bfly_lat(MUL_LAT);

    logic [L-1:0]              vld_q, vld_d;
    logic [K-1:0]              a0_q, a0_d, b0_q, b0_d, w0_q, w0_d;
    logic [MUL_LAT-1:0][K-1:0] a_dly_q, a_dly_d;
    logic [K-1:0]              mul_x, mul_y, prod, ct_x0, ct_x1;
    logic                      mode_q;

    always_comb begin
        vld_d   = {vld_q[L-2:0], bus.in_valid};
        a0_d    = bus.a;
        b0_d    = bus.b;
        w0_d    = bus.w;
        a_dly_d = {a_dly_q[MUL_LAT-2:0], a0_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_q <= '0;
        else
            vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
        a0_q    <= a0_d;
        b0_q    <= b0_d;
        w0_q    <= w0_d;
        a_dly_q <= a_dly_d;
    end

    assign bus.busy      = |vld_q;
    assign bus.out_valid = vld_q[L-1];

    mod_multiplication #(.K(K), .LAT(MUL_LAT)) u_mul (
        .clk (clk),
        .a   (mul_x),
        .b   (mul_y),
        .p   (prod)
    );

    // CT: a delayed to meet w*b, then the registered add/sub is the output stage
    mod_addsub #(.K(K)) u_ct (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a_dly_q[MUL_LAT-1]),
        .b      (prod),
        .sum_q  (ct_x0),
        .diff_q (ct_x1)
    );

`ifdef NTT_BUTTERFLY_INV_EN
    logic                      mode_d;
    logic [K-1:0]              w1_q, w1_d, gs_sum, gs_diff;
    logic [MUL_LAT-1:0][K-1:0] sum_dly_q, sum_dly_d;

    // mode only switches with the pipe empty, so every in-flight beat shares mode_q
    always_comb begin
        mode_d    = bus.busy ? mode_q : bus.mode;
        w1_d      = w0_q;
        sum_dly_d = {sum_dly_q[MUL_LAT-2:0], gs_sum};
        mul_x     = mode_q ? gs_diff : b0_q;
        mul_y     = mode_q ? w1_q : w0_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mode_q <= 1'b0;
        else
            mode_q <= mode_d;
    end

    always_ff @(posedge clk) begin
        w1_q      <= w1_d;
        sum_dly_q <= sum_dly_d;
    end

    mod_addsub #(.K(K)) u_gs (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a0_q),
        .b      (b0_q),
        .sum_q  (gs_sum),
        .diff_q (gs_diff)
    );

    // reset clears mode_q, which selects the reset CT registers, so x0/x1 read 0
    assign bus.x0 = mode_q ? sum_dly_q[MUL_LAT-1] : ct_x0;
    assign bus.x1 = mode_q ? prod : ct_x1;
`else
    always_comb begin
        mul_x = b0_q;
        mul_y = w0_q;
    end

    assign mode_q = bus.mode & 1'b0;
    assign bus.x0 = ct_x0;
    assign bus.x1 = ct_x1;
`endif
endmodule
